// File: rtl/instr_queue.sv
// instr_queue: circular FIFO of fetched instructions between the fetcher and
// the decoder. Each entry holds a pc and an instruction. The head entry is
// always presented on pc_to_dc/instr_to_dc (first-word fall-through), and a
// flush discards every entry on a branch redirect.
//
// Optional build macro INSTR_QUEUE_ALMOST_FULL_EN adds almost_full_to_fetcher,
// which is high whenever the queue holds DEPTH-2 or more entries. This gives
// the fetcher slack for memory reads that are already in flight.
module instr_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PC_W       = 32,
    parameter int INSTR_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push_from_fetcher,
    input  logic [PC_W-1:0]       pc_from_fetcher,
    input  logic [INSTR_W-1:0]    instr_from_fetcher,
    output logic                  is_full_to_fetcher,
`ifdef INSTR_QUEUE_ALMOST_FULL_EN
    output logic                  almost_full_to_fetcher,
`endif
    input  logic                  pop_from_dc,
    output logic                  is_empty_to_dc,
    output logic [PC_W-1:0]       pc_to_dc,
    output logic [INSTR_W-1:0]    instr_to_dc,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [PC_W-1:0]       pc_mem    [DEPTH];
    logic [INSTR_W-1:0]    instr_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;

    logic                  is_empty;
    logic                  is_full;
    logic                  pop_ok;
    logic                  push_ok;

    // Occupancy flags come straight from the count register, so they follow
    // the asynchronous reset immediately. A push into a full queue is
    // allowed only when the head is popped in the same cycle.
    always_comb begin
        is_empty = (count == '0);
        is_full  = (count == CNT_FULL);
        pop_ok   = pop_from_dc && !is_empty;
        push_ok  = push_from_fetcher && (!is_full || pop_ok);
    end

    // Pointer and occupancy tracking. Flush outranks push and pop, and a
    // simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + PTR_ONE;
            end
            if (pop_ok) begin
                head <= head + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Entry storage is not reset. A slot only becomes visible after the
    // count says it is occupied, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (!flush && push_ok) begin
            pc_mem[tail]    <= pc_from_fetcher;
            instr_mem[tail] <= instr_from_fetcher;
        end
    end

    // Fall-through outputs show the head entry, forced to zero when the
    // queue is empty so the decoder never sees stale data.
    always_comb begin
        is_empty_to_dc     = is_empty;
        is_full_to_fetcher = is_full;
        pc_to_dc           = is_empty ? '0 : pc_mem[head];
        instr_to_dc        = is_empty ? '0 : instr_mem[head];
    end

`ifdef INSTR_QUEUE_ALMOST_FULL_EN
    localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 2);

    // Early throttle for the fetcher. Because count resets to 0, this is
    // also low under reset.
    always_comb begin
        almost_full_to_fetcher = (count >= CNT_ALMOST);
    end
`endif

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed self-checking bench for instr_queue. Each scenario
// task drives its own stimulus and compares the outputs against
// hand-computed values.
module tb_instr_queue;

    localparam int DEPTH_LOG2 = 4;
    localparam int PC_W       = 32;
    localparam int INSTR_W    = 32;

    logic                clk;
    logic                rst;
    logic                flush;
    logic                push_from_fetcher;
    logic [PC_W-1:0]     pc_from_fetcher;
    logic [INSTR_W-1:0]  instr_from_fetcher;
    logic                is_full_to_fetcher;
    logic                pop_from_dc;
    logic                is_empty_to_dc;
    logic [PC_W-1:0]     pc_to_dc;
    logic [INSTR_W-1:0]  instr_to_dc;
    logic [DEPTH_LOG2:0] count;
`ifdef INSTR_QUEUE_ALMOST_FULL_EN
    logic                almost_full_to_fetcher;
`endif

    int compared   = 0;
    int mismatched = 0;

    instr_queue #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .flush                  (flush),
        .push_from_fetcher      (push_from_fetcher),
        .pc_from_fetcher        (pc_from_fetcher),
        .instr_from_fetcher     (instr_from_fetcher),
        .is_full_to_fetcher     (is_full_to_fetcher),
`ifdef INSTR_QUEUE_ALMOST_FULL_EN
        .almost_full_to_fetcher (almost_full_to_fetcher),
`endif
        .pop_from_dc            (pop_from_dc),
        .is_empty_to_dc         (is_empty_to_dc),
        .pc_to_dc               (pc_to_dc),
        .instr_to_dc            (instr_to_dc),
        .count                  (count)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one clock cycle of requests, then returns 1 ns after the edge.
    task automatic cycle(input logic p, input logic q, input logic f,
                         input logic [PC_W-1:0] pc_v, input logic [INSTR_W-1:0] in_v);
        push_from_fetcher  = p;
        pop_from_dc        = q;
        flush              = f;
        pc_from_fetcher    = pc_v;
        instr_from_fetcher = in_v;
        @(posedge clk);
        #1;
        push_from_fetcher  = 1'b0;
        pop_from_dc        = 1'b0;
        flush              = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        push_from_fetcher = 1'b0;
        pop_from_dc = 1'b0;
        pc_from_fetcher = '0;
        instr_from_fetcher = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
        compared++;
        if (is_empty_to_dc !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_empty: got %b expected 1", is_empty_to_dc); end
        compared++;
        if (count !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        compared++;
        if (pc_to_dc !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_pc: got %h expected 0", pc_to_dc); end
        compared++;
        if (instr_to_dc !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instr: got %h expected 0", instr_to_dc); end
        compared++;
        if (is_full_to_fetcher !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %b expected 0", is_full_to_fetcher); end
`ifdef INSTR_QUEUE_ALMOST_FULL_EN
        compared++;
        if (almost_full_to_fetcher !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_afull: got %b expected 0", almost_full_to_fetcher); end
`endif
    endtask

    task automatic test_single_push_pop();
        // A pop on an empty queue must not underflow the count.
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        compared++;
        if (count !== 5'd0) begin mismatched++; $display("[TB] FAIL empty_pop_count: got %0d expected 0", count); end
        cycle(1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0537);
        compared++;
        if (is_empty_to_dc !== 1'b0) begin mismatched++; $display("[TB] FAIL single_empty: got %b expected 0", is_empty_to_dc); end
        compared++;
        if (pc_to_dc !== 32'h0000_0004) begin mismatched++; $display("[TB] FAIL single_pc: got %h expected 00000004", pc_to_dc); end
        compared++;
        if (instr_to_dc !== 32'h0000_0537) begin mismatched++; $display("[TB] FAIL single_instr: got %h expected 00000537", instr_to_dc); end
        compared++;
        if (count !== 5'd1) begin mismatched++; $display("[TB] FAIL single_count: got %0d expected 1", count); end
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        compared++;
        if (is_empty_to_dc !== 1'b1) begin mismatched++; $display("[TB] FAIL single_pop_empty: got %b expected 1", is_empty_to_dc); end
        compared++;
        if (count !== 5'd0) begin mismatched++; $display("[TB] FAIL single_pop_count: got %0d expected 0", count); end
    endtask

    task automatic test_fill_wrap();
        logic [PC_W-1:0]    exp_pc;
        logic [INSTR_W-1:0] exp_instr;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'(4 * i), 32'(32'h1000 + i));
`ifdef INSTR_QUEUE_ALMOST_FULL_EN
            compared++;
            if (almost_full_to_fetcher !== ((i + 1) >= 14)) begin
                mismatched++; $display("[TB] FAIL fill_afull[%0d]: got %b expected %b", i, almost_full_to_fetcher, ((i + 1) >= 14));
            end
`endif
        end
        compared++;
        if (is_full_to_fetcher !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_full: got %b expected 1", is_full_to_fetcher); end
        compared++;
        if (count !== 5'd16) begin mismatched++; $display("[TB] FAIL fill_count: got %0d expected 16", count); end
        // A push while full with no pop is dropped.
        cycle(1'b1, 1'b0, 1'b0, 32'h40, 32'hDEAD);
        compared++;
        if (count !== 5'd16) begin mismatched++; $display("[TB] FAIL overfill_count: got %0d expected 16", count); end
        compared++;
        if (pc_to_dc !== 32'h0) begin mismatched++; $display("[TB] FAIL overfill_head: got %h expected 0", pc_to_dc); end
        repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, '0);
        compared++;
        if (count !== 5'd13) begin mismatched++; $display("[TB] FAIL pop3_count: got %0d expected 13", count); end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'(32'h40 + 4 * k), 32'(32'h2000 + k));
        end
        compared++;
        if (count !== 5'd16) begin mismatched++; $display("[TB] FAIL wrap_count: got %0d expected 16", count); end
        for (int i = 0; i < 16; i++) begin
            exp_pc    = (i < 13) ? 32'(4 * (i + 3)) : 32'(64 + 4 * (i - 13));
            exp_instr = (i < 13) ? 32'(4096 + i + 3) : 32'(8192 + i - 13);
            compared++;
            if (pc_to_dc !== exp_pc) begin mismatched++; $display("[TB] FAIL drain_pc[%0d]: got %h expected %h", i, pc_to_dc, exp_pc); end
            compared++;
            if (instr_to_dc !== exp_instr) begin mismatched++; $display("[TB] FAIL drain_instr[%0d]: got %h expected %h", i, instr_to_dc, exp_instr); end
            cycle(1'b0, 1'b1, 1'b0, '0, '0);
`ifdef INSTR_QUEUE_ALMOST_FULL_EN
            compared++;
            if (almost_full_to_fetcher !== ((15 - i) >= 14)) begin
                mismatched++; $display("[TB] FAIL drain_afull[%0d]: got %b expected %b", i, almost_full_to_fetcher, ((15 - i) >= 14));
            end
`endif
        end
        compared++;
        if (is_empty_to_dc !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_empty: got %b expected 1", is_empty_to_dc); end
    endtask

    task automatic test_back_to_back();
        logic [PC_W-1:0] exp_pc;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'(32'h100 + 4 * i), 32'(32'h3000 + i));
        end
        // Push and pop together while full: the count holds, the head advances.
        cycle(1'b1, 1'b1, 1'b0, 32'h200, 32'h4000);
        compared++;
        if (count !== 5'd16) begin mismatched++; $display("[TB] FAIL full_pp_count: got %0d expected 16", count); end
        compared++;
        if (is_full_to_fetcher !== 1'b1) begin mismatched++; $display("[TB] FAIL full_pp_full: got %b expected 1", is_full_to_fetcher); end
        for (int i = 0; i < 16; i++) begin
            exp_pc = (i < 15) ? 32'(32'h100 + 4 * (i + 1)) : 32'h200;
            compared++;
            if (pc_to_dc !== exp_pc) begin mismatched++; $display("[TB] FAIL full_pp_drain[%0d]: got %h expected %h", i, pc_to_dc, exp_pc); end
            if (i == 15) begin
                compared++;
                if (instr_to_dc !== 32'h4000) begin mismatched++; $display("[TB] FAIL full_pp_instr: got %h expected 00004000", instr_to_dc); end
            end
            cycle(1'b0, 1'b1, 1'b0, '0, '0);
        end
        compared++;
        if (count !== 5'd0) begin mismatched++; $display("[TB] FAIL full_pp_end_count: got %0d expected 0", count); end
        // Push and pop together while empty: only the push takes effect.
        cycle(1'b1, 1'b1, 1'b0, 32'h300, 32'h5000);
        compared++;
        if (count !== 5'd1) begin mismatched++; $display("[TB] FAIL empty_pp_count: got %0d expected 1", count); end
        compared++;
        if (pc_to_dc !== 32'h300) begin mismatched++; $display("[TB] FAIL empty_pp_pc: got %h expected 00000300", pc_to_dc); end
        compared++;
        if (is_empty_to_dc !== 1'b0) begin mismatched++; $display("[TB] FAIL empty_pp_empty: got %b expected 0", is_empty_to_dc); end
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'(32'h400 + 4 * i), 32'(32'h6000 + i));
        end
        compared++;
        if (count !== 5'd5) begin mismatched++; $display("[TB] FAIL flush_pre_count: got %0d expected 5", count); end
        cycle(1'b1, 1'b1, 1'b1, 32'h500, 32'h7000);
        compared++;
        if (count !== 5'd0) begin mismatched++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
        compared++;
        if (is_empty_to_dc !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_empty: got %b expected 1", is_empty_to_dc); end
        compared++;
        if (pc_to_dc !== 32'h0) begin mismatched++; $display("[TB] FAIL flush_pc: got %h expected 0", pc_to_dc); end
        cycle(1'b1, 1'b0, 1'b0, 32'h600, 32'h8000);
        compared++;
        if (pc_to_dc !== 32'h600) begin mismatched++; $display("[TB] FAIL post_flush_pc: got %h expected 00000600", pc_to_dc); end
        compared++;
        if (count !== 5'd1) begin mismatched++; $display("[TB] FAIL post_flush_count: got %0d expected 1", count); end
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'(32'h700 + 4 * i), 32'(32'h9000 + i));
        end
        compared++;
        if (count !== 5'd7) begin mismatched++; $display("[TB] FAIL arst_pre_count: got %0d expected 7", count); end
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (is_empty_to_dc !== 1'b1) begin mismatched++; $display("[TB] FAIL arst_empty: got %b expected 1", is_empty_to_dc); end
        compared++;
        if (instr_to_dc !== 32'h0) begin mismatched++; $display("[TB] FAIL arst_instr: got %h expected 0", instr_to_dc); end
        compared++;
        if (count !== 5'd0) begin mismatched++; $display("[TB] FAIL arst_count: got %0d expected 0", count); end
        // A push held across an edge inside reset must not complete.
        push_from_fetcher  = 1'b1;
        pc_from_fetcher    = 32'h800;
        instr_from_fetcher = 32'hA000;
        @(posedge clk);
        #1;
        push_from_fetcher = 1'b0;
        rst = 1'b1;
        compared++;
        if (count !== 5'd0) begin mismatched++; $display("[TB] FAIL arst_push_count: got %0d expected 0", count); end
        cycle(1'b1, 1'b0, 1'b0, 32'h900, 32'hB000);
        compared++;
        if (pc_to_dc !== 32'h900) begin mismatched++; $display("[TB] FAIL arst_recover_pc: got %h expected 00000900", pc_to_dc); end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_single_push_pop();
        test_fill_wrap();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Circular FIFO of fetched instructions. Each entry holds a pc and an instr.
- Sits between the instruction fetcher (upstream) and the decoder `dc` (downstream), and feeds `dc` through the is_empty/pc/instr interface.
- First-word fall-through: the head entry is always visible on the outputs without a read request.
- A flush clears all contents on branch redirect.

Parameters:
- DEPTH_LOG2, 4, log2 of the entry count (DEPTH = 16).
- PC_W, 32, pc width (matches `PcLength`+1).
- INSTR_W, 32, instruction width (matches `InstrLength`+1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  discard all entries (redirect/mispredict).
- push_from_fetcher  input  1  write request from the fetcher.
- pc_from_fetcher  input  PC_W  pc of the instruction being pushed.
- instr_from_fetcher  input  INSTR_W  instruction being pushed.
- is_full_to_fetcher  output  1  queue holds DEPTH entries.
- pop_from_dc  input  1  decoder consumes the head entry this cycle.
- is_empty_to_dc  output  1  queue holds 0 entries.
- pc_to_dc  output  PC_W  pc of the head entry.
- instr_to_dc  output  INSTR_W  instruction of the head entry.
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.

Behaviour:
- State:
  - head and tail pointers, DEPTH_LOG2 bits each, wrap modulo DEPTH.
  - count register.
  - storage arrays for pc and instr.
- Reset (rst=0, asynchronous):
  - head=0, tail=0, count=0.
  - Outputs go immediately to is_empty_to_dc=1, is_full_to_fetcher=0, pc_to_dc=0, instr_to_dc=0.
  - Storage contents need not be reset.
- Reset asserted mid-operation: all entries are lost; no pop or push completes on that edge.
- Derived signals:
  - is_empty = (count==0).
  - is_full = (count==DEPTH).
  - Both are decoded combinationally from the count register.
- Accepted push: push_from_fetcher && (!is_full || pop_ok).
- Accepted pop (pop_ok): pop_from_dc && !is_empty.
- Per rising edge:
  - flush=1:
    - head=tail=0, count=0.
    - Any simultaneous push or pop is discarded.
    - Flush has the highest priority after reset.
  - Otherwise, accepted push:
    - mem[tail] <= {pc, instr}, tail <= tail+1.
    - Tail wraps from DEPTH-1 to 0.
  - Otherwise, accepted pop: head <= head+1, with the same wrap rule.
  - Count update:
    - +1 for push only.
    - −1 for pop only.
    - Unchanged for both or neither.
- Simultaneous push+pop:
  - When full: both are accepted, count stays DEPTH.
  - When empty: only the push is accepted (pop is ignored), count becomes 1.
- Push while full with no pop: ignored, no state change, no overwrite.
- Pop while empty: ignored, count never underflows.
- Outputs:
  - pc_to_dc/instr_to_dc = mem[head] when !is_empty, else 0.
  - These are combinational from the registers.
  - Latency: a push at edge N is visible at the outputs after edge N (one cycle push-to-visible). There is no same-cycle bypass from the input to the output.
- Pop semantics: the head shown in cycle N is consumed at edge N; the next entry appears after that edge.

Optional Feature:
- Macro: INSTR_QUEUE_ALMOST_FULL_EN.
- When defined:
  - Adds output port almost_full_to_fetcher (1 bit) = (count >= DEPTH-2), combinational.
  - Value is 0 under reset.
  - Gives the fetcher two cycles of slack for in-flight memory reads.
- When undefined:
  - The port does not exist.
  - The fetcher throttles on is_full_to_fetcher only.
- Core FIFO behaviour is identical in both builds.

Test Plan:
- Reset then idle:
  - Hold rst=0 for 2 cycles, release.
  - Expect is_empty_to_dc=1, count=0, pc_to_dc=0, instr_to_dc=0, is_full_to_fetcher=0.
- Single push/pop:
  - Push pc=32'h0000_0004, instr=32'h0000_0537.
  - Next cycle expect is_empty_to_dc=0 and outputs show those values.
  - Pop; next cycle expect is_empty_to_dc=1, count=0.
- Fill and wrap:
  - Push 16 entries with pc=4*i, i=0..15.
  - Expect is_full_to_fetcher=1, count=16.
  - A 17th push (pc=32'h40) is ignored.
  - Pop 3 and push pc=32'h40, 32'h44, 32'h48; the tail wraps.
  - Drain; expect pc order 0xC…0x3C, 0x40, 0x44, 0x48.
- Simultaneous push+pop:
  - When full: count stays 16, head advances by one, the new entry lands at the old head slot.
  - When empty: count=1, the pushed entry is visible next cycle.
- Flush:
  - With count=5, assert flush together with push and pop.
  - Next cycle expect count=0 and is_empty_to_dc=1; the pushed entry is absent.
  - A subsequent push appears at head slot 0.
- Async reset mid-stream:
  - With count=7, drop rst between clock edges.
  - Expect is_empty_to_dc=1 and instr_to_dc=0 before the next edge.
  - With the macro defined, almost_full_to_fetcher rises at count=14 and falls at count=13.
